// File: rtl/lsu_rmw.sv
// ============================================================================
//  lsu_rmw : RV32I load/store unit for a single-port word memory without byte
//            enables. Sub-word stores are performed as read-modify-write.
//  Optional: `define LSU_MISALIGN_ERR_EN to report misaligned/illegal accesses.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_rmw #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RESP = 2'd1,
    RMW_WR    = 2'd2,
    ACK       = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic [15:0]           wdata_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  req_illegal;
  logic                  req_err;
  logic [2:0]            f3_eff;
  logic [1:0]            off_eff;
  logic                  unused_addr_bits;

  assign req_idx          = req_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // Illegal codes collapse to a word access and offsets are aligned down to
  // the access size; when error reporting is enabled these requests never
  // reach the datapath, so the normalisation is harmless there.
  always_comb begin
    if (req_we)
      req_illegal = req_funct3[2] || (req_funct3 == 3'b011);
    else
      req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                    (req_funct3 == 3'b111);
    f3_eff = req_illegal ? 3'b010 : req_funct3;
    case (f3_eff[1:0])
      2'b00:   off_eff = req_addr[1:0];
      2'b01:   off_eff = {req_addr[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_ERR_EN
  logic req_misalign;
  assign req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err      = req_illegal || req_misalign;
`else
  assign req_err      = 1'b0;
`endif

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  always_comb begin
    byte_sel = mem_dout[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (f3_q[1:0])
      2'b00:   load_ext = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: load_ext = mem_dout;
    endcase
    merged = mem_dout;
    if (f3_q[1:0] == 2'b00)
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = (state_q == IDLE);
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = idx_q;
    mem_din    = merged;
    case (state_q)
      IDLE: begin
        mem_addr = req_idx;
        mem_din  = req_wdata;
        if (req_valid) begin
          if (req_err) begin
            state_d = ACK;
          end else if (req_we) begin
            if (f3_eff[1:0] == 2'b10) begin
              mem_we  = 1'b1;
              state_d = ACK;
            end else begin
              state_d = RMW_WR;
            end
          end else begin
            state_d = LOAD_RESP;
          end
        end
      end
      LOAD_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = load_ext;
        state_d    = IDLE;
      end
      RMW_WR: begin
        mem_we  = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      wdata_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_valid && req_ready) begin
        idx_q   <= req_idx;
        off_q   <= off_eff;
        f3_q    <= f3_eff;
        wdata_q <= req_wdata[15:0];
        err_q   <= req_err;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_rmw.sv
// ============================================================================
//  tb_lsu_rmw : directed vector bench for lsu_rmw with a synchronous memory.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_rmw;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  lsu_rmw #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic          we;
    logic [2:0]    f3;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    int            exp_lat;
    logic          exp_we0;
    logic [AW-1:0] exp_maddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input int lat, input logic we0,
                              input logic [AW-1:0] maddr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = rdata;
    v.exp_err = err; v.exp_lat = lat; v.exp_we0 = we0; v.exp_maddr = maddr;
    return v;
  endfunction

  // Issue one request from IDLE and check accept-cycle memory signals and response.
  task automatic run_vec(input vec_t v, input int n);
    int          lat;
    logic [31:0] rd;
    logic        er;
    lat = 0; rd = 32'd0; er = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    chk($sformatf("v%0d.ready", n), {31'd0, req_ready}, 32'd1);
    chk($sformatf("v%0d.mem_we_acc", n), {31'd0, mem_we}, {31'd0, v.exp_we0});
    chk($sformatf("v%0d.mem_addr_acc", n), {22'd0, mem_addr}, {22'd0, v.exp_maddr});
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    chk($sformatf("v%0d.latency", n), lat, v.exp_lat);
    chk($sformatf("v%0d.rdata", n), rd, v.exp_rdata);
    chk($sformatf("v%0d.err", n), {31'd0, er}, {31'd0, v.exp_err});
  endtask

  logic        b_we    [3];
  logic [2:0]  b_f3    [3];
  logic [31:0] b_addr  [3];
  logic [31:0] b_wdata [3];

  task automatic drive_b(input int i);
    req_valid = 1'b1; req_we = b_we[i]; req_funct3 = b_f3[i];
    req_addr = b_addr[i]; req_wdata = b_wdata[i];
  endtask

  initial begin
    int          acc_cyc [3];
    int          nreq;
    logic        accepted;
    logic [31:0] rsp [$];

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.ready", {31'd0, req_ready}, 32'd1);
    chk("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset.mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset.rdata", resp_rdata, 32'd0);
    chk("reset.err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;

    //            we    f3      addr       wdata          rdata         err  lat we0  maddr
    vecs.push_back(mk(1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0, 1, 1, 10'd4));
    vecs.push_back(mk(0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0, 1, 0, 10'd4));
    vecs.push_back(mk(1, 3'b010, 32'h20,   32'h11223344, 32'h0,        0, 1, 1, 10'd8));
    vecs.push_back(mk(0, 3'b000, 32'h23,   32'h0,        32'h00000011, 0, 1, 0, 10'd8));
    vecs.push_back(mk(0, 3'b001, 32'h22,   32'h0,        32'h00001122, 0, 1, 0, 10'd8));
    vecs.push_back(mk(0, 3'b101, 32'h20,   32'h0,        32'h00003344, 0, 1, 0, 10'd8));
    vecs.push_back(mk(1, 3'b000, 32'h20,   32'h00000080, 32'h0,        0, 2, 0, 10'd8));
    vecs.push_back(mk(0, 3'b000, 32'h20,   32'h0,        32'hFFFFFF80, 0, 1, 0, 10'd8));
    vecs.push_back(mk(0, 3'b100, 32'h20,   32'h0,        32'h00000080, 0, 1, 0, 10'd8));
    vecs.push_back(mk(1, 3'b010, 32'h20,   32'h11223344, 32'h0,        0, 1, 1, 10'd8));
    vecs.push_back(mk(1, 3'b000, 32'h21,   32'hFFFFFFAB, 32'h0,        0, 2, 0, 10'd8));
    vecs.push_back(mk(0, 3'b010, 32'h20,   32'h0,        32'h1122AB44, 0, 1, 0, 10'd8));
    vecs.push_back(mk(1, 3'b001, 32'h22,   32'h1234BEEF, 32'h0,        0, 2, 0, 10'd8));
    vecs.push_back(mk(0, 3'b010, 32'h20,   32'h0,        32'hBEEFAB44, 0, 1, 0, 10'd8));
    vecs.push_back(mk(0, 3'b001, 32'h22,   32'h0,        32'hFFFFBEEF, 0, 1, 0, 10'd8));
    vecs.push_back(mk(0, 3'b000, 32'h21,   32'h0,        32'hFFFFFFAB, 0, 1, 0, 10'd8));
    vecs.push_back(mk(0, 3'b010, 32'h1020, 32'h0,        32'hBEEFAB44, 0, 1, 0, 10'd8));
`ifdef LSU_MISALIGN_ERR_EN
    vecs.push_back(mk(0, 3'b010, 32'h22,   32'h0,        32'h0,        1, 1, 0, 10'd8));
    vecs.push_back(mk(0, 3'b011, 32'h20,   32'h0,        32'h0,        1, 1, 0, 10'd8));
    vecs.push_back(mk(1, 3'b010, 32'h13,   32'h12345678, 32'h0,        1, 1, 0, 10'd4));
    vecs.push_back(mk(0, 3'b001, 32'h21,   32'h0,        32'h0,        1, 1, 0, 10'd8));
    vecs.push_back(mk(0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0, 1, 0, 10'd4));
`else
    vecs.push_back(mk(0, 3'b010, 32'h22,   32'h0,        32'hBEEFAB44, 0, 1, 0, 10'd8));
    vecs.push_back(mk(0, 3'b011, 32'h20,   32'h0,        32'hBEEFAB44, 0, 1, 0, 10'd8));
    vecs.push_back(mk(1, 3'b010, 32'h13,   32'h12345678, 32'h0,        0, 1, 1, 10'd4));
    vecs.push_back(mk(0, 3'b001, 32'h21,   32'h0,        32'hFFFFAB44, 0, 1, 0, 10'd8));
    vecs.push_back(mk(0, 3'b010, 32'h10,   32'h0,        32'h12345678, 0, 1, 0, 10'd4));
`endif
    vecs.push_back(mk(1, 3'b010, 32'h30,   32'h11223344, 32'h0,        0, 1, 1, 10'd12));
    vecs.push_back(mk(1, 3'b010, 32'h40,   32'h55667788, 32'h0,        0, 1, 1, 10'd16));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while the RMW write is on the bus: the write must be abandoned.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h31; req_wdata = 32'h000000AB;
    @(negedge clk);
    chk("rmwrst.accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmwrst.mem_we", {31'd0, mem_we}, 32'd1);
    chk("rmwrst.mem_din", mem_din, 32'h1122AB44);
    chk("rmwrst.mem_addr", {22'd0, mem_addr}, 32'd12);
    #1 rst = 1'b1;
    #1;
    chk("rmwrst.mem_we_after", {31'd0, mem_we}, 32'd0);
    chk("rmwrst.ready_after", {31'd0, req_ready}, 32'd1);
    chk("rmwrst.resp_valid_after", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(0, 3'b010, 32'h30, 32'h0, 32'h11223344, 0, 1, 0, 10'd12), 100);

    // Back-to-back SB, LW, SW with valid held until each is accepted.
    b_we[0] = 1'b1; b_f3[0] = 3'b000; b_addr[0] = 32'h41; b_wdata[0] = 32'h000000CD;
    b_we[1] = 1'b0; b_f3[1] = 3'b010; b_addr[1] = 32'h40; b_wdata[1] = 32'h0;
    b_we[2] = 1'b1; b_f3[2] = 3'b010; b_addr[2] = 32'h44; b_wdata[2] = 32'hCAFEF00D;
    foreach (acc_cyc[i]) acc_cyc[i] = -1;
    nreq = 0;
    @(posedge clk); #1;
    drive_b(0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (resp_valid) rsp.push_back(resp_rdata);
      accepted = req_valid && req_ready;
      if (accepted && nreq < 3) begin
        acc_cyc[nreq] = cyc;
        nreq++;
      end
      @(posedge clk); #1;
      if (accepted) begin
        if (nreq < 3) drive_b(nreq);
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b.accepts", nreq, 3);
    chk("b2b.acc0", acc_cyc[0], 0);
    chk("b2b.acc1", acc_cyc[1], 3);
    chk("b2b.acc2", acc_cyc[2], 5);
    chk("b2b.responses", rsp.size(), 3);
    if (rsp.size() >= 2) chk("b2b.lw_rdata", rsp[1], 32'h5566CD88);
    else chk("b2b.lw_rdata_missing", rsp.size(), 2);
    run_vec(mk(0, 3'b010, 32'h44, 32'h0, 32'hCAFEF00D, 0, 1, 0, 10'd17), 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
